// File: rtl/intr_pend_if.sv
`default_nettype none
// ============================================================================
// Module   : intr_pend_if
// Brief    : 8-bit register bus between software and intr_pend.
// Revision : 1.0 - initial release
// ============================================================================
interface intr_pend_if;
  logic [7:0] paddr_i;
  logic [7:0] pwdata_i;
  logic       pwrite_i;
  logic       penable_i;
  logic [7:0] prdata_o;
  logic       pready_o;
  logic       perror_o;

  modport master (
    output paddr_i, pwdata_i, pwrite_i, penable_i,
    input  prdata_o, pready_o, perror_o
  );

  modport slave (
    input  paddr_i, pwdata_i, pwrite_i, penable_i,
    output prdata_o, pready_o, perror_o
  );
endinterface
`default_nettype wire

// File: rtl/intr_pend.sv
`default_nettype none
// ============================================================================
// Module   : intr_pend
// Brief    : IRQ synchroniser, edge/level/polarity/mask capture and pending
//            register feeding intr_ctrl. Optional glitch filter enabled by
//            defining INTR_PEND_GLITCH_FILTER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module intr_pend #(
  parameter int NUM_INTR    = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 3
) (
  input  wire logic                pclk_i,
  input  wire logic                prst_i,
  intr_pend_if.slave               bus,
  input  wire logic [NUM_INTR-1:0] irq_raw_i,
  input  wire logic [3:0]          intr_to_service_i,
  input  wire logic                intr_serviced_i,
  output logic      [NUM_INTR-1:0] intr_active_o
);

  logic [NUM_INTR-1:0] r_sync [SYNC_STAGES];
  logic [NUM_INTR-1:0] r_mode, r_pol, r_mask, r_pend, r_lvl_d;
  logic                r_pready, r_perror;
  logic [7:0]          r_prdata;

  logic [NUM_INTR-1:0] w_pol_in, w_lvl, w_rise;
  logic [NUM_INTR-1:0] w_wdata, w_wbyte, w_mode_nxt, w_mode_chg;
  logic [NUM_INTR-1:0] w_w1c, w_svc, w_pend_nxt;
  logic [15:0]         w_wdata16, w_wbyte16, w_sel16;
  logic [7:0]          w_rdata;
  logic                w_acc, w_wr, w_addr_ok;

  always_ff @(posedge pclk_i or negedge prst_i) begin
    if (!prst_i) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
    end else begin
      r_sync[0] <= irq_raw_i;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  assign w_pol_in = r_sync[SYNC_STAGES-1] ^ r_pol;

`ifdef INTR_PEND_GLITCH_FILTER_EN
  localparam int c_CNT_W = $clog2(FILT_CYCLES + 1);
  logic [NUM_INTR-1:0] r_filt;

  // Each line only flips after FILT_CYCLES consecutive disagreeing samples.
  for (genvar gi = 0; gi < NUM_INTR; gi++) begin : g_filt
    logic [c_CNT_W-1:0] r_cnt;
    always_ff @(posedge pclk_i or negedge prst_i) begin
      if (!prst_i) begin
        r_cnt      <= '0;
        r_filt[gi] <= 1'b0;
      end else if (w_pol_in[gi] == r_filt[gi]) begin
        r_cnt      <= '0;
      end else if (r_cnt == c_CNT_W'(FILT_CYCLES - 1)) begin
        r_cnt      <= '0;
        r_filt[gi] <= w_pol_in[gi];
      end else begin
        r_cnt      <= r_cnt + 1'b1;
      end
    end
  end
  assign w_lvl = r_filt;
`else
  assign w_lvl = w_pol_in;
`endif

  assign w_rise = w_lvl & ~r_lvl_d;

  assign w_acc     = bus.penable_i & ~r_pready;
  assign w_addr_ok = (bus.paddr_i < 8'h0A);
  assign w_wr      = w_acc & bus.pwrite_i & w_addr_ok;

  always_comb begin
    w_sel16 = 16'h0000;
    case (bus.paddr_i[7:1])
      7'd0:    w_sel16 = 16'(r_mode);
      7'd1:    w_sel16 = 16'(r_pol);
      7'd2:    w_sel16 = 16'(r_mask);
      7'd3:    w_sel16 = 16'(r_pend);
      7'd4:    w_sel16 = 16'(w_lvl);
      default: w_sel16 = 16'h0000;
    endcase
  end

  assign w_rdata   = bus.paddr_i[0] ? w_sel16[15:8] : w_sel16[7:0];
  assign w_wdata16 = bus.paddr_i[0] ? {bus.pwdata_i, 8'h00} : {8'h00, bus.pwdata_i};
  assign w_wbyte16 = bus.paddr_i[0] ? 16'hFF00 : 16'h00FF;
  assign w_wdata   = w_wdata16[NUM_INTR-1:0];
  assign w_wbyte   = w_wbyte16[NUM_INTR-1:0];

  assign w_mode_nxt = (r_mode & ~w_wbyte) | w_wdata;
  assign w_mode_chg = (w_wr && bus.paddr_i[7:1] == 7'd0) ? (w_mode_nxt ^ r_mode) : '0;
  assign w_w1c      = (w_wr && bus.paddr_i[7:1] == 7'd3) ? w_wdata : '0;
  assign w_svc      = (intr_serviced_i && 32'(intr_to_service_i) < NUM_INTR)
                      ? (NUM_INTR'(1) << intr_to_service_i) : '0;

  // Edge set beats any clear in the same cycle; a mode switch always empties the bit.
  assign w_pend_nxt = ~w_mode_chg &
                      ((~r_mode & w_lvl) | (r_mode & (w_rise | (r_pend & ~(w_w1c | w_svc)))));

  always_ff @(posedge pclk_i or negedge prst_i) begin
    if (!prst_i) begin
      r_mode   <= '0;
      r_pol    <= '0;
      r_mask   <= '0;
      r_pend   <= '0;
      r_lvl_d  <= '0;
      r_pready <= 1'b0;
      r_perror <= 1'b0;
      r_prdata <= 8'h00;
    end else begin
      r_pend   <= w_pend_nxt;
      r_lvl_d  <= w_lvl;
      r_pready <= w_acc;
      r_perror <= w_acc & ~w_addr_ok;
      r_prdata <= (w_acc && w_addr_ok) ? w_rdata : 8'h00;
      if (w_wr && bus.paddr_i[7:1] == 7'd0) r_mode <= w_mode_nxt;
      if (w_wr && bus.paddr_i[7:1] == 7'd1) r_pol  <= (r_pol  & ~w_wbyte) | w_wdata;
      if (w_wr && bus.paddr_i[7:1] == 7'd2) r_mask <= (r_mask & ~w_wbyte) | w_wdata;
    end
  end

  assign bus.pready_o  = r_pready;
  assign bus.perror_o  = r_perror;
  assign bus.prdata_o  = r_prdata;
  assign intr_active_o = r_pend & r_mask;

endmodule
`default_nettype wire
